// File: rtl/fifo_pop_checker.sv
// fifo_pop_checker: consumer end of the FIFO pop interface.
// Pops words through a 2-entry skid buffer (one word per cycle), checks the
// parity bit in the MSB of each word and presents payload plus error flag
// downstream. Optional macro FIFO_POP_ERR_CNT_EN adds a saturating count of
// errored words delivered (err_cnt port).
module fifo_pop_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int ODD_PARITY    = 0,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pop_valid_in,
  input  logic [DATA_WIDTH:0]   pop_data_in,
  output logic                  pop_grant_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_par_err,
  input  logic                  err_clr,
  output logic                  err_sticky
`ifdef FIFO_POP_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RESET,
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  localparam logic ODD_BIT = (ODD_PARITY != 0);

  state_t                state;
  state_t                next_state;
  logic                  pop;
  logic                  drain;
  logic                  in_err;
  logic                  load_out;
  logic                  load_skid;
  logic                  move_skid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_err;

  // Grant and valid are pure functions of the occupancy state, so the FIFO
  // never sees a combinational path from out_ready.
  assign pop_grant_out = (state == S_EMPTY) || (state == S_ONE);
  assign out_valid     = (state == S_ONE) || (state == S_TWO);
  assign pop           = pop_valid_in & pop_grant_out;
  assign drain         = out_valid & out_ready;

  // A word is errored when its total XOR differs from the selected parity sense.
  assign in_err = (^pop_data_in) ^ ODD_BIT;

  // The output register takes a new word when it is empty or being drained at
  // the same time; otherwise an incoming word parks in the skid register.
  assign load_out  = (state == S_EMPTY && pop) || (state == S_ONE && pop && drain);
  assign load_skid = (state == S_ONE) && pop && !drain;
  assign move_skid = (state == S_TWO) && drain;

  // State register; reset parks the FSM in RESET for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic tracking how many words are buffered.
  always_comb begin
    next_state = state;
    unique case (state)
      S_RESET: next_state = S_EMPTY;
      S_EMPTY: begin
        if (pop) next_state = S_ONE;
      end
      S_ONE: begin
        if (pop && !drain) begin
          next_state = S_TWO;
        end else if (!pop && drain) begin
          next_state = S_EMPTY;
        end
      end
      S_TWO: begin
        if (drain) next_state = S_ONE;
      end
      default: next_state = S_RESET;
    endcase
  end

  // Output and skid registers; the output pair only changes on a load, so it
  // stays stable while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_par_err <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
    end else begin
      if (load_out) begin
        out_data    <= pop_data_in[DATA_WIDTH-1:0];
        out_par_err <= in_err;
      end else if (move_skid) begin
        out_data    <= skid_data;
        out_par_err <= skid_err;
      end
      if (load_skid) begin
        skid_data <= pop_data_in[DATA_WIDTH-1:0];
        skid_err  <= in_err;
      end
    end
  end

  // Sticky error flag; a new errored delivery beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (drain && out_par_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef FIFO_POP_ERR_CNT_EN
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  // Saturating errored-word counter; clear with a simultaneous error restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= (drain && out_par_err) ? CNT_ONE : '0;
    end else if (drain && out_par_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end
`endif

endmodule
